// File: rtl/iob_axis_byte_packer_pkg.sv
// -----------------------------------------------------------------------------
// iob_axis_byte_packer_pkg
// Shared definitions for the RX byte packer:
//   - state_t        : packer FSM state encoding (S_RUN accepts bytes,
//                      S_HOLD waits for the frame status handshake)
//   - bytes_per_word : number of byte lanes in an output word
//   - lane_width     : width of the lane counter for a given word width
// -----------------------------------------------------------------------------
package iob_axis_byte_packer_pkg;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int lane_width(input int data_w);
        return (data_w / 8 > 1) ? $clog2(data_w / 8) : 1;
    endfunction

endpackage

// File: rtl/iob_axis_byte_packer_sat_counter.sv
// -----------------------------------------------------------------------------
// iob_sat_counter
// Saturating up-counter with synchronous clear, used for the per-frame byte
// and word counts of the packer.
// Ports:
//   clk_i   in  clock
//   cke_i   in  clock enable; the count holds when 0
//   rst_i   in  synchronous active-high reset
//   inc     in  increment request (ignored once the count is all-ones)
//   clr     in  clear; wins over inc, so the register restarts at 0
//   cnt_nxt out count including this cycle's increment (pre-clear value)
//   sat     out cnt_nxt has reached all-ones
// -----------------------------------------------------------------------------
module iob_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         cke_i,
    input  logic         rst_i,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt_nxt,
    output logic         sat
);

    logic [W-1:0] cnt_q;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and a latch is never inferred.
    always_comb begin
        cnt_nxt = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_nxt = cnt_q + W'(1);
        end
    end

    assign sat = (cnt_nxt == '1);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (cke_i) begin
            cnt_q <= clr ? '0 : cnt_nxt;
        end
    end

endmodule

// File: rtl/iob_axis_byte_packer.sv
// -----------------------------------------------------------------------------
// iob_axis_byte_packer
// Packs an 8-bit RX byte stream into AXI_DATA_W-bit AXIS words, zero-pads the
// last partial word of each frame and reports per-frame byte/word counts.
// Configuration macro: IOB_AXIS_BYTE_PACKER_BIG_ENDIAN_EN
//   defined   : byte k lands in bits [AXI_DATA_W-8k-1 -: 8] (network order)
//   undefined : byte k lands in bits [8k+7:8k] (little endian)
// Ports:
//   clk_i, cke_i, rst_i     clock, clock enable, synchronous active-high reset
//   rx_tdata_i/tvalid_i/tlast_i, rx_tready_o        byte input stream
//   axis_out_tdata_o/tvalid_o/tlast_o, axis_out_tready_i   packed word output
//   frame_valid_o, frame_ready_i                    frame status handshake
//   frame_bytes_o, frame_words_o, frame_err_o       completed frame status
// -----------------------------------------------------------------------------
module iob_axis_byte_packer
    import iob_axis_byte_packer_pkg::*;
#(
    parameter int AXI_DATA_W = 32,
    parameter int WLEN_W     = 12,
    parameter int BCNT_W     = 14
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  rst_i,
    input  logic [7:0]            rx_tdata_i,
    input  logic                  rx_tvalid_i,
    input  logic                  rx_tlast_i,
    output logic                  rx_tready_o,
    output logic [AXI_DATA_W-1:0] axis_out_tdata_o,
    output logic                  axis_out_tvalid_o,
    input  logic                  axis_out_tready_i,
    output logic                  axis_out_tlast_o,
    output logic                  frame_valid_o,
    input  logic                  frame_ready_i,
    output logic [BCNT_W-1:0]     frame_bytes_o,
    output logic [WLEN_W-1:0]     frame_words_o,
    output logic                  frame_err_o
);

    localparam int NB     = bytes_per_word(AXI_DATA_W);
    localparam int LANE_W = lane_width(AXI_DATA_W);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NB - 1);

    state_t                state_q;
    logic [LANE_W-1:0]     lane_q;
    logic [AXI_DATA_W-1:0] acc_q;
    logic [AXI_DATA_W-1:0] acc_nxt;
    logic                  accept;
    logic                  word_done;
    logic                  frame_end;
    logic [BCNT_W-1:0]     bytes_nxt;
    logic                  bytes_sat;
    logic [WLEN_W-1:0]     words_nxt;
    logic                  words_sat;

    // Back-pressure applies to every byte: a byte is only taken when a word
    // completed by it could load the output register on the same edge.
    assign rx_tready_o = (state_q == S_RUN) && (!axis_out_tvalid_o || axis_out_tready_i);
    assign accept      = rx_tvalid_i && rx_tready_o;
    assign frame_end   = accept && rx_tlast_i;
    assign word_done   = accept && ((lane_q == LAST_LANE) || rx_tlast_i);

    // Accumulator with the current byte merged into its lane. Lanes above the
    // current one are still zero, which gives the padding of a partial word.
    always_comb begin
        acc_nxt = acc_q;
`ifdef IOB_AXIS_BYTE_PACKER_BIG_ENDIAN_EN
        acc_nxt[AXI_DATA_W - 8 - 8 * int'(lane_q) +: 8] = rx_tdata_i;
`else
        acc_nxt[8 * int'(lane_q) +: 8] = rx_tdata_i;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q           <= S_RUN;
            lane_q            <= '0;
            acc_q             <= '0;
            axis_out_tdata_o  <= '0;
            axis_out_tvalid_o <= 1'b0;
            axis_out_tlast_o  <= 1'b0;
            frame_valid_o     <= 1'b0;
            frame_bytes_o     <= '0;
            frame_words_o     <= '0;
            frame_err_o       <= 1'b0;
        end else if (cke_i) begin
            // Output register: word_done implies the register is free or
            // handshaking this cycle, so a load never overwrites a live word.
            if (word_done) begin
                axis_out_tdata_o  <= acc_nxt;
                axis_out_tvalid_o <= 1'b1;
                axis_out_tlast_o  <= rx_tlast_i;
            end else if (axis_out_tready_i) begin
                axis_out_tvalid_o <= 1'b0;
            end

            if (accept) begin
                if (word_done) begin
                    lane_q <= '0;
                    acc_q  <= '0;
                end else begin
                    lane_q <= lane_q + LANE_W'(1);
                    acc_q  <= acc_nxt;
                end
            end

            case (state_q)
                S_RUN: begin
                    if (frame_end) begin
                        state_q       <= S_HOLD;
                        frame_valid_o <= 1'b1;
                        frame_bytes_o <= bytes_nxt;
                        frame_words_o <= words_nxt;
                        frame_err_o   <= bytes_sat || words_sat;
                    end
                end
                S_HOLD: begin
                    if (frame_ready_i) begin
                        state_q       <= S_RUN;
                        frame_valid_o <= 1'b0;
                    end
                end
                default: state_q <= S_RUN;
            endcase
        end
    end

    iob_sat_counter #(.W(BCNT_W)) u_byte_cnt (
        .clk_i   (clk_i),
        .cke_i   (cke_i),
        .rst_i   (rst_i),
        .inc     (accept),
        .clr     (frame_end),
        .cnt_nxt (bytes_nxt),
        .sat     (bytes_sat)
    );

    iob_sat_counter #(.W(WLEN_W)) u_word_cnt (
        .clk_i   (clk_i),
        .cke_i   (cke_i),
        .rst_i   (rst_i),
        .inc     (word_done),
        .clr     (frame_end),
        .cnt_nxt (words_nxt),
        .sat     (words_sat)
    );

endmodule
